// File: rtl/slug_pkg.sv
// Shared types for the slug single-clock phase sequencer.
// Provides phase/state enums and a counter-width helper.
package slug_pkg;

  typedef enum logic [1:0] {
    PH_P,
    PH_U,
    PH_R,
    PH_W
  } phase_t;

  typedef enum logic [1:0] {
    HOLD,
    IDLE,
    RUN,
    STEP
  } seq_state_t;

  // Width of a counter holding 0..n-1, at least 1 bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/slug_prescaler.sv
// Slot counter 0..DIV-1 on sysclk; tick marks the last slot.
// Ports: clk, rst (async high), start (sync clear), en, slot, tick.
module slug_prescaler
  import slug_pkg::*;
#(
  parameter int DIV = 4,
  parameter int SW  = cnt_w(DIV)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          en,
  output logic [SW-1:0] slot,
  output logic          tick
);

  assign tick = en && (slot == SW'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot <= '0;
    end else if (start) begin
      slot <= '0;
    end else if (en) begin
      slot <= tick ? '0 : slot + 1'b1;
    end
  end

endmodule

// File: rtl/slug_phase_seq.sv
// One-clock P/U/R/W phase-enable sequencer with run/step/halt and post-reset hold.
// Ports: sysclk, rst, run_req, step_req, halt_req in; core_rst, p/u/r/w_en, running, step_done, instr_count out.
module slug_phase_seq
  import slug_pkg::*;
#(
  parameter int DIV      = 4,
  parameter int RST_HOLD = 16,
  parameter int CNT_W    = 32
) (
  input  logic             sysclk,
  input  logic             rst,
  input  logic             run_req,
  input  logic             step_req,
  input  logic             halt_req,
  output logic             core_rst,
  output logic             p_en,
  output logic             u_en,
  output logic             r_en,
  output logic             w_en,
  output logic             running,
  output logic             step_done,
  output logic [CNT_W-1:0] instr_count
);

  localparam int SW = cnt_w(DIV);
  localparam int HW = cnt_w(RST_HOLD + 1);

  seq_state_t       state, state_n;
  phase_t           phase, phase_n;
  logic [HW-1:0]    hold_cnt, hold_n;
  logic             halt_q, halt_n;
  logic             run_block, block_n;
  logic             w_step, w_step_n;
  logic [SW-1:0]    slot;
  logic             tick;
  logic             active;
  logic             slot0;
  logic             last;
  logic             stop;
  logic             core_rst_n;
  logic             p_n, u_n, r_n, w_n;
  logic             running_n;
  logic             step_done_n;
  logic [CNT_W-1:0] cnt_n;

  // Slot/phase are held at zero outside RUN/STEP so every
  // instruction starts cleanly with P in slot 0.
  slug_prescaler #(
    .DIV (DIV),
    .SW  (SW)
  ) u_presc (
    .clk   (sysclk),
    .rst   (rst),
    .start (!active),
    .en    (active),
    .slot  (slot),
    .tick  (tick)
  );

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state       <= HOLD;
      phase       <= PH_P;
      hold_cnt    <= '0;
      halt_q      <= 1'b0;
      run_block   <= 1'b0;
      w_step      <= 1'b0;
      core_rst    <= 1'b1;
      p_en        <= 1'b0;
      u_en        <= 1'b0;
      r_en        <= 1'b0;
      w_en        <= 1'b0;
      running     <= 1'b0;
      step_done   <= 1'b0;
      instr_count <= '0;
    end else begin
      state       <= state_n;
      phase       <= phase_n;
      hold_cnt    <= hold_n;
      halt_q      <= halt_n;
      run_block   <= block_n;
      w_step      <= w_step_n;
      core_rst    <= core_rst_n;
      p_en        <= p_n;
      u_en        <= u_n;
      r_en        <= r_n;
      w_en        <= w_n;
      running     <= running_n;
      step_done   <= step_done_n;
      instr_count <= cnt_n;
    end
  end

  always_comb begin
    active  = (state == RUN) || (state == STEP);
    slot0   = (slot == '0);
    // The cycle that launches w_en is the instruction boundary.
    last    = active && slot0 && (phase == PH_W);
    stop    = 1'b0;
    state_n = state;
    hold_n  = hold_cnt;
    halt_n  = halt_q;
    // A halted run stays parked until run_req is seen low again.
    block_n = run_block && run_req;

    unique case (state)
      HOLD: begin
        if (hold_cnt == HW'(RST_HOLD)) begin
          state_n = IDLE;
        end else begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      IDLE: begin
        halt_n = 1'b0;
        if (run_req) begin
          if (!run_block) begin
            state_n = RUN;
          end
        end else if (step_req) begin
          state_n = STEP;
        end
      end
      RUN: begin
        halt_n = halt_q || halt_req;
        stop   = !run_req || halt_n;
        if (last && stop) begin
          state_n = IDLE;
          block_n = run_req && halt_n;
          halt_n  = 1'b0;
        end
      end
      STEP: begin
        if (last) begin
          state_n = IDLE;
        end
      end
      default: state_n = HOLD;
    endcase

    phase_n = PH_P;
    if (active) begin
      phase_n = tick ? phase_t'(phase + 2'd1) : phase;
    end

    core_rst_n  = (state_n == HOLD);
    p_n         = active && slot0 && (phase == PH_P);
    u_n         = active && slot0 && (phase == PH_U);
    r_n         = active && slot0 && (phase == PH_R);
    w_n         = last;
    running_n   = active;
    w_step_n    = last && (state == STEP);
    step_done_n = w_step;
    cnt_n       = instr_count + CNT_W'(w_en);
  end

endmodule

// File: tb/tb_slug_phase_seq.sv
// Directed bench for slug_phase_seq (DIV=4 main instance, DIV=1 second instance).
// Checks hold, step, run, halt, run/step priority, mid-instruction reset.
module tb_slug_phase_seq;

  logic        clk = 1'b0;
  logic        rst, rst1;
  logic        run_req, step_req, halt_req;

  logic        core_rst, p_en, u_en, r_en, w_en, running, step_done;
  logic [31:0] instr_count;
  logic        core_rst1, p_en1, u_en1, r_en1, w_en1, running1, step_done1;
  logic [31:0] instr_count1;

  logic [3:0]  en0, en1, exp_en;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          pulses, multi, badp, pcnt, wcnt, sd;

  assign en0 = {p_en, u_en, r_en, w_en};
  assign en1 = {p_en1, u_en1, r_en1, w_en1};

  always #5 clk = ~clk;

  slug_phase_seq #(.DIV(4), .RST_HOLD(16), .CNT_W(32)) dut (
    .sysclk      (clk),
    .rst         (rst),
    .run_req     (run_req),
    .step_req    (step_req),
    .halt_req    (halt_req),
    .core_rst    (core_rst),
    .p_en        (p_en),
    .u_en        (u_en),
    .r_en        (r_en),
    .w_en        (w_en),
    .running     (running),
    .step_done   (step_done),
    .instr_count (instr_count)
  );

  slug_phase_seq #(.DIV(1), .RST_HOLD(16), .CNT_W(32)) dut1 (
    .sysclk      (clk),
    .rst         (rst1),
    .run_req     (run_req),
    .step_req    (step_req),
    .halt_req    (halt_req),
    .core_rst    (core_rst1),
    .p_en        (p_en1),
    .u_en        (u_en1),
    .r_en        (r_en1),
    .w_en        (w_en1),
    .running     (running1),
    .step_done   (step_done1),
    .instr_count (instr_count1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (17) tick();
    chk("reset_to_idle", 32'(core_rst), 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    rst1     = 1'b1;
    run_req  = 1'b0;
    step_req = 1'b0;
    halt_req = 1'b0;
    tick();
    tick();

    // 1: reset values and post-reset hold
    chk("rst_core_rst", 32'(core_rst), 32'd1);
    chk("rst_en", 32'(en0), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_step_done", 32'(step_done), 32'd0);
    chk("rst_count", instr_count, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("hold_core_rst", 32'(core_rst), 32'd1);
      chk("hold_en", 32'(en0), 32'd0);
    end
    tick();
    chk("hold_release", 32'(core_rst), 32'd0);

    // 2: single step
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    chk("step_k_en", 32'(en0), 32'd0);
    for (int j = 1; j <= 16; j++) begin
      tick();
      exp_en = (j == 1)  ? 4'b1000 :
               (j == 5)  ? 4'b0100 :
               (j == 9)  ? 4'b0010 :
               (j == 13) ? 4'b0001 : 4'b0000;
      chk("step_en", 32'(en0), 32'(exp_en));
      chk("step_running", 32'(running), 32'(j <= 13));
      chk("step_done", 32'(step_done), 32'(j == 14));
      chk("step_count", instr_count, 32'(j >= 14));
    end

    // 3: continuous run for 40 cycles
    do_reset();
    pulses = 0;
    multi  = 0;
    badp   = 0;
    pcnt   = 0;
    run_req = 1'b1;
    for (int j = 0; j <= 60; j++) begin
      tick();
      if (j == 39) run_req = 1'b0;
      pulses += $countones(en0);
      if ($countones(en0) > 1) multi++;
      if (p_en) begin
        pcnt++;
        if (j != 1 && j != 17 && j != 33) badp++;
      end
    end
    chk("run_pulses", 32'(pulses), 32'd12);
    chk("run_multi", 32'(multi), 32'd0);
    chk("run_p_timing", 32'(badp), 32'd0);
    chk("run_p_count", 32'(pcnt), 32'd3);
    chk("run_count", instr_count, 32'd3);
    chk("run_stopped", 32'(running), 32'd0);

    // 4: halt on the r_en cycle
    pcnt = 0;
    wcnt = 0;
    run_req = 1'b1;
    for (int j = 0; j <= 40; j++) begin
      tick();
      if (j == 9) begin
        chk("halt_r_en", 32'(r_en), 32'd1);
        halt_req = 1'b1;
      end
      if (j == 10) halt_req = 1'b0;
      if (j == 13) chk("halt_w_en", 32'(w_en), 32'd1);
      pcnt += int'(p_en);
      wcnt += int'(w_en);
    end
    chk("halt_p_count", 32'(pcnt), 32'd1);
    chk("halt_w_count", 32'(wcnt), 32'd1);
    chk("halt_count", instr_count, 32'd4);
    chk("halt_idle", 32'(running), 32'd0);
    run_req = 1'b0;
    tick();
    tick();
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    tick();
    chk("rerun_p_en", 32'(p_en), 32'd1);
    repeat (20) tick();
    chk("rerun_count", instr_count, 32'd5);
    chk("rerun_idle", 32'(running), 32'd0);

    // 5: run and step together -> run wins
    sd = 0;
    run_req  = 1'b1;
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    for (int j = 1; j <= 40; j++) begin
      tick();
      if (j == 1) chk("both_p_en", 32'(p_en), 32'd1);
      if (j == 20) run_req = 1'b0;
      sd += int'(step_done);
    end
    chk("both_no_step_done", 32'(sd), 32'd0);
    chk("both_count", instr_count, 32'd7);
    chk("both_idle", 32'(running), 32'd0);

    // 6: reset during the u_en slot, then DIV=1 step
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    repeat (5) tick();
    chk("mid_u_en", 32'(u_en), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_en", 32'(en0), 32'd0);
    chk("mid_rst_count", instr_count, 32'd0);
    chk("mid_rst_core_rst", 32'(core_rst), 32'd1);
    chk("mid_rst_running", 32'(running), 32'd0);
    rst  = 1'b0;
    rst1 = 1'b0;
    tick();
    chk("rehold_0", 32'(core_rst), 32'd1);
    repeat (15) tick();
    chk("rehold_15", 32'(core_rst), 32'd1);
    tick();
    chk("rehold_16", 32'(core_rst), 32'd0);
    chk("div1_hold_16", 32'(core_rst1), 32'd0);

    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    chk("div1_k_en", 32'(en1), 32'd0);
    for (int j = 1; j <= 6; j++) begin
      tick();
      exp_en = (j == 1) ? 4'b1000 :
               (j == 2) ? 4'b0100 :
               (j == 3) ? 4'b0010 :
               (j == 4) ? 4'b0001 : 4'b0000;
      chk("div1_en", 32'(en1), 32'(exp_en));
      chk("div1_running", 32'(running1), 32'(j <= 4));
      chk("div1_step_done", 32'(step_done1), 32'(j == 5));
      chk("div1_count", instr_count1, 32'(j >= 5));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
